dot_matrix_scan_ctrl: RTL
=========================

Name: dot_matrix_scan_ctrl

Overview:
Row-scan multiplexing controller for the 8x8 red/green water-level dot matrix. It does the following:
- Time-multiplexes one active-low row at a time.
- Drives the bar-graph column pattern for the current water level.
- Inserts an anti-ghosting blank at the start of each row slot.
- Blinks the full display at level 15.
It sits between the water-level sensing logic and the matrix pins. The level is sampled only at frame boundaries, so no frame ever shows a mix of two levels.

Parameters:
SCAN_DIV, 6250, clk cycles per row slot (50 MHz gives a 1 kHz frame rate); legal range >= 2
BLANK_CYCLES, 16, cycles at the start of each row slot with all outputs blanked; must be < SCAN_DIV
BLINK_FRAMES, 250, frames per blink half-period at level 15 (gives 2 Hz at defaults); must be >= 1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
water_level  input  4  water level in metres, 0-15 (15 means over 14 m)
row_data  output  8  row drive, active-low, one-hot; bit0 = bottom row
red_column_data  output  8  red column drive, active-high
green_column_data  output  8  green column drive, active-high
frame_start  output  1  one-cycle pulse when row 0 begins a new frame
alarm  output  1  high while the latched level is >= 13

Behaviour:
- Reset (rst low, asynchronous):
  - div_cnt = 0, row_idx = 0, level_reg = 0, frame_cnt = 0, blink_on = 1.
  - Outputs: row_data = 8'hFF, both column buses = 8'h00, frame_start = 0, alarm = 0.
- Counters:
  - div_cnt runs 0..SCAN_DIV-1 and wraps to 0.
  - At div_cnt == SCAN_DIV-1 (the "slot tick"), row_idx increments, wrapping 7 -> 0.
- Frame boundary (slot tick while row_idx == 7):
  - level_reg <= water_level.
  - frame_start pulses high on the next cycle, for exactly 1 cycle.
  - The blink logic below updates.
  - A water_level change mid-frame has no effect until the next boundary.
- Lit-row count N from level_reg:
  - 0-6 -> 2; 7-8 -> 3; 9-10 -> 4; 11-12 -> 5; 13 -> 6; 14 -> 7; 15 -> 8.
- Colour from level_reg:
  - 0-6 green only.
  - 7-12 red and green (yellow).
  - 13-15 red only.
- Blink:
  - When level_reg != 15: frame_cnt is held at 0 and blink_on is held at 1.
  - When level_reg == 15: at each frame boundary, frame_cnt increments. On reaching BLINK_FRAMES-1 it clears and blink_on toggles.
  - On a transition into 15, the blink starts with blink_on = 1.
- Output registers (1-cycle latency from the counter state):
  - Blank, when div_cnt < BLANK_CYCLES or blink_on == 0: row_data = 8'hFF, columns = 0.
  - Otherwise, row_data = ~(1 << row_idx).
  - Each colour column bus = 8'hFF if that colour is enabled and row_idx < N, else 8'h00.
  - Unlit rows are still scanned (row asserted) with their columns at 0.
- alarm is registered from level_reg >= 13, so it updates 1 cycle after the boundary.
- At most one row_data bit is ever low in any cycle.
- A reset mid-frame returns every register to its reset value immediately. Scanning restarts at row 0 after rst deasserts, with the first sampled level applied at the first frame boundary (level_reg = 0 until then, i.e. 2 green rows).

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
1. Reset and idle: hold rst low, then release with water_level=0 -> row_data=FF and columns=00 during reset. Afterwards, rows sweep FE, FD, FB ... 7F with 8 cycles per slot, the first 2 cycles of each slot blanked (FF/00). green=FF only in slots 0-1, red=00 always; frame_start pulses every 64 cycles.
2. Level 9 steady -> rows 0-3 show red=FF and green=FF, rows 4-7 show columns 00 with the row still asserted; alarm=0.
3. Mid-frame change from 6 to 13 while row_idx=3 -> the current frame stays green with 2 rows. The next frame is red-only with 6 rows; alarm rises 1 cycle after the frame_start boundary.
4. Level 15 -> all 8 rows red for 2 frames, then the whole display is blank (FF/00) for 2 frames, repeating. Changing to 14 -> steady 7 red rows, blink_on forced to 1.
5. Assert rst mid-slot at row 5 with level 12 -> outputs go FF/00 asynchronously. After release, scanning restarts at row 0 showing 2 green rows until the first boundary, then 5 yellow rows.
6. Checker across all levels 0-15 -> never more than one row_data bit low, and never any nonzero column during the blank cycles.

Source files
------------

// File: rtl/dot_matrix_scan_ctrl.sv
// Row-scan multiplexer for the 8x8 red/green water-level matrix: one active-low
// row per slot, bar-graph columns per level, anti-ghost blank and level-15 blink.
module dot_matrix_scan_ctrl #(
   parameter int SCAN_DIV     = 6250,
   parameter int BLANK_CYCLES = 16,
   parameter int BLINK_FRAMES = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] water_level,
   output logic [7:0] row_data,
   output logic [7:0] red_column_data,
   output logic [7:0] green_column_data,
   output logic       frame_start,
   output logic       alarm
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
   localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
   localparam logic [FC_W-1:0]  FC_LAST   = FC_W'(BLINK_FRAMES - 1);

   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       row_idx;
   logic [3:0]       level_reg;
   logic [FC_W-1:0]  frame_cnt;
   logic             blink_on;

   logic             slot_tick;
   logic             frame_tick;
   logic [3:0]       n_lit;
   logic             row_lit;
   logic             red_en;
   logic             green_en;
   logic             blank;

   // Number of lit rows (counted from the bottom) for a given level.
   function automatic logic [3:0] lit_rows(input logic [3:0] lvl);
      logic [3:0] n;
      case (lvl)
         4'd7, 4'd8:   n = 4'd3;
         4'd9, 4'd10:  n = 4'd4;
         4'd11, 4'd12: n = 4'd5;
         4'd13:        n = 4'd6;
         4'd14:        n = 4'd7;
         4'd15:        n = 4'd8;
         default:      n = 4'd2;
      endcase
      return n;
   endfunction

   always_comb begin
      slot_tick  = (div_cnt == DIV_LAST);
      frame_tick = slot_tick && (row_idx == 3'd7);
      n_lit      = lit_rows(level_reg);
      row_lit    = ({1'b0, row_idx} < n_lit);
      red_en     = (level_reg >= 4'd7);
      green_en   = (level_reg <= 4'd12);
      blank      = (div_cnt < BLANK_END) || !blink_on;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt <= '0;
         row_idx <= 3'd0;
      end else if (slot_tick) begin
         div_cnt <= '0;
         row_idx <= row_idx + 3'd1;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Blink state follows the level being latched, so a frame entering level 15
   // always starts lit and any other level keeps the display steady.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         level_reg <= 4'd0;
         frame_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (frame_tick) begin
         level_reg <= water_level;
         if (water_level != 4'd15 || level_reg != 4'd15) begin
            frame_cnt <= '0;
            blink_on  <= 1'b1;
         end else if (frame_cnt == FC_LAST) begin
            frame_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            frame_cnt <= frame_cnt + FC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_data          <= 8'hFF;
         red_column_data   <= 8'h00;
         green_column_data <= 8'h00;
         frame_start       <= 1'b0;
         alarm             <= 1'b0;
      end else begin
         frame_start <= frame_tick;
         alarm       <= (level_reg >= 4'd13);
         if (blank) begin
            row_data          <= 8'hFF;
            red_column_data   <= 8'h00;
            green_column_data <= 8'h00;
         end else begin
            row_data          <= ~(8'h01 << row_idx);
            red_column_data   <= (red_en && row_lit) ? 8'hFF : 8'h00;
            green_column_data <= (green_en && row_lit) ? 8'hFF : 8'h00;
         end
      end
   end

endmodule
